// File: rtl/fetch_step_controller.sv
// Run/halt/single-step sequencer for the single-cycle fetch datapath.
// Owns the PC freeze, gates architectural commit and counts retired instructions.
module fetch_step_controller #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter logic [31:0] HALT_OPCODE  = 32'hFFFF_FFFF,
    parameter bit          RUN_ON_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        runReq,
    input  logic        haltReq,
    input  logic        stepReq,
    input  logic        bpEnable,
    input  logic [31:0] bpAddress,
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic        freeze,
    output logic        commit,
    output logic        halted,
    output logic [1:0]  state,
    output logic [1:0]  haltCause,
    output logic [31:0] instrCount
);

    typedef enum logic [1:0] {
        S_HALTED = 2'd0,
        S_FETCH  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD    = 4'(MEM_LATENCY - 1);
    localparam state_t     RESET_STATE = RUN_ON_RESET ? S_FETCH : S_HALTED;
    // Leaving reset straight into FETCH must still wait the full memory latency.
    localparam logic [3:0] RESET_CNT   = RUN_ON_RESET ? CNT_LOAD : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        stepMode_q, stepMode_d;
    logic        skipBp_q, skipBp_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] count_q, count_d;

    logic isHaltOp;
    logic commitEn;
    logic firstFetch;
    logic bpHit;

    always_comb begin
        isHaltOp   = (instruction == HALT_OPCODE);
        commitEn   = (state_q == S_COMMIT) && !isHaltOp && !reset;
        firstFetch = (cnt_q == CNT_LOAD);
        bpHit      = bpEnable && (pc == bpAddress) && !skipBp_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        stepMode_d = stepMode_q;
        skipBp_d   = skipBp_q;
        cause_d    = cause_q;
        count_d    = count_q;

        case (state_q)
            S_HALTED: begin
                if (runReq || stepReq) begin
                    state_d    = S_FETCH;
                    cnt_d      = CNT_LOAD;
                    stepMode_d = !runReq;
                    skipBp_d   = 1'b1;
                    cause_d    = 2'd0;
                end
            end
            S_FETCH: begin
                if (firstFetch) begin
                    skipBp_d = 1'b0;
                end
                if (haltReq) begin
                    state_d = S_HALTED;
                    cause_d = 2'd1;
                end else if (firstFetch && bpHit) begin
                    state_d = S_HALTED;
                    cause_d = 2'd2;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_COMMIT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_COMMIT: begin
                if (isHaltOp) begin
                    state_d = S_HALTED;
                    cause_d = 2'd3;
                end else begin
                    // A halt request arriving now lets this instruction retire first.
                    count_d = count_q + 32'd1;
                    if (stepMode_q || haltReq) begin
                        state_d = S_HALTED;
                        cause_d = 2'd1;
                    end else begin
                        state_d = S_FETCH;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            cnt_q      <= RESET_CNT;
            stepMode_q <= 1'b0;
            skipBp_q   <= 1'b0;
            cause_q    <= 2'd0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stepMode_q <= stepMode_d;
            skipBp_q   <= skipBp_d;
            cause_q    <= cause_d;
            count_q    <= count_d;
        end
    end

    assign freeze     = !commitEn;
    assign commit     = commitEn;
    assign halted     = (state_q == S_HALTED);
    assign state      = state_q;
    assign haltCause  = cause_q;
    assign instrCount = count_q;

endmodule
